// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter that shares one uart_tx between N_REQ byte producers.
// A grant is held until a Last byte finishes on the line or the owner stays idle for MAX_GAP cycles.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int MAX_GAP = 1024,
    parameter int GAP_W   = 11,
    localparam int IDX_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                 i_Clock,
    input  logic                 i_Rst_n,
    input  logic [N_REQ-1:0]     i_Req_Valid,
    input  logic [8*N_REQ-1:0]   i_Req_Data,
    input  logic [N_REQ-1:0]     i_Req_Last,
    output logic [N_REQ-1:0]     o_Req_Ready,
    output logic [N_REQ-1:0]     o_Grant,
    output logic                 o_Busy,
    output logic                 o_Tx_DV,
    output logic [7:0]           o_Tx_Byte,
    input  logic                 i_Tx_Active,
    input  logic                 i_Tx_Done,
    output logic [1:0]           o_Dbg_State,
    output logic [IDX_W-1:0]     o_Dbg_Rr
);

    // Handshake: a requester byte moves when i_Req_Valid[k] & o_Req_Ready[k] are both high at a rising edge;
    // o_Req_Ready never depends on i_Req_Valid, and valid may be dropped at any time.
    localparam logic [1:0] ST_ARB       = 2'd0;
    localparam logic [1:0] ST_HOLD      = 2'd1;
    localparam logic [1:0] ST_WAIT_ACT  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [GAP_W-1:0] gap_q, gap_d;
    logic             last_q, last_d;
    logic             tx_dv_q, tx_dv_d;
    logic [7:0]       tx_byte_q, tx_byte_d;

    logic             tx_free;
    logic             owner_valid;
    logic             owner_last;
    logic [7:0]       owner_data;
    logic             xfer;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [IDX_W-1:0] rr_next;
    logic [GAP_W-1:0] gap_inc;
    logic             gap_hit;

    // The second Done cycle and uart CLEANUP both drop a DV, so only a fully idle uart counts as free.
    assign tx_free = !i_Tx_Active && !i_Tx_Done;

    always_comb begin
        owner_valid = 1'b0;
        owner_last  = 1'b0;
        owner_data  = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            if (owner_q == IDX_W'(k)) begin
                owner_valid = i_Req_Valid[k];
                owner_last  = i_Req_Last[k];
                owner_data  = i_Req_Data[8*k +: 8];
            end
        end
    end

    always_comb begin
        int cand;
        cand       = 0;
        pick_found = 1'b0;
        pick_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            cand = int'(rr_q) + i;
            if (cand >= N_REQ) cand = cand - N_REQ;
            if (!pick_found && i_Req_Valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    assign xfer    = (state_q == ST_HOLD) && owner_valid && tx_free;
    assign rr_next = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
    assign gap_inc = (gap_q == GAP_W'(MAX_GAP)) ? gap_q : gap_q + GAP_W'(1);
    assign gap_hit = (MAX_GAP != 0) && (gap_inc == GAP_W'(MAX_GAP));

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        rr_d      = rr_q;
        gap_d     = gap_q;
        last_d    = last_q;
        tx_dv_d   = 1'b0;
        tx_byte_d = tx_byte_q;
        case (state_q)
            ST_ARB: begin
                if (pick_found) begin
                    owner_d = pick_idx;
                    gap_d   = '0;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (xfer) begin
                    tx_byte_d = owner_data;
                    tx_dv_d   = 1'b1;
                    last_d    = owner_last;
                    gap_d     = '0;
                    state_d   = ST_WAIT_ACT;
                end else if (!owner_valid) begin
                    gap_d = gap_inc;
                    if (gap_hit) begin
                        rr_d    = rr_next;
                        owner_d = '0;
                        state_d = ST_ARB;
                    end
                end
            end
            ST_WAIT_ACT: begin
                if (i_Tx_Active) state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (i_Tx_Done) begin
                    if (last_q) begin
                        rr_d    = rr_next;
                        owner_d = '0;
                        state_d = ST_ARB;
                    end else begin
                        state_d = ST_HOLD;
                    end
                end
            end
            default: state_d = ST_ARB;
        endcase
    end

    always_ff @(posedge i_Clock or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            state_q   <= ST_ARB;
            owner_q   <= '0;
            rr_q      <= '0;
            gap_q     <= '0;
            last_q    <= 1'b0;
            tx_dv_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            rr_q      <= rr_d;
            gap_q     <= gap_d;
            last_q    <= last_d;
            tx_dv_q   <= tx_dv_d;
            tx_byte_q <= tx_byte_d;
        end
    end

    always_comb begin
        o_Req_Ready = '0;
        o_Grant     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if ((state_q != ST_ARB) && (owner_q == IDX_W'(k))) begin
                o_Grant[k]     = 1'b1;
                o_Req_Ready[k] = (state_q == ST_HOLD) && tx_free;
            end
        end
    end

    assign o_Busy      = (state_q != ST_ARB);
    assign o_Tx_DV     = tx_dv_q;
    assign o_Tx_Byte   = tx_byte_q;
    assign o_Dbg_State = state_q;
    assign o_Dbg_Rr    = rr_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: a uart_tx behavioural model (CLKS_PER_BIT=27, no reset) drives the serial line,
// which is decoded and scored against hand-written expected bytes.
module tb_uart_tx_arbiter;

    localparam int N       = 4;
    localparam int CPB     = 27;
    localparam int MAX_GAP = 16;
    localparam int GAP_W   = 5;
    localparam logic [1:0] S_ARB   = 2'd0;
    localparam logic [1:0] S_HOLD  = 2'd1;
    localparam logic [1:0] S_WDONE = 2'd3;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N-1:0]   req_last = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_ready;
    logic [N-1:0]   grant;
    logic           busy;
    logic           tx_dv;
    logic [7:0]     tx_byte;
    logic           tx_active = 1'b0;
    logic           tx_done = 1'b0;
    logic           tx_serial = 1'b1;
    logic [1:0]     dbg_state;
    logic [1:0]     dbg_rr;

    int n_checks = 0;
    int n_errors = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    uart_tx_arbiter #(.N_REQ(N), .MAX_GAP(MAX_GAP), .GAP_W(GAP_W)) dut (
        .i_Clock(clk), .i_Rst_n(rst_n),
        .i_Req_Valid(req_valid), .i_Req_Data(req_data), .i_Req_Last(req_last),
        .o_Req_Ready(req_ready), .o_Grant(grant), .o_Busy(busy),
        .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
        .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
        .o_Dbg_State(dbg_state), .o_Dbg_Rr(dbg_rr)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // uart_tx model: IDLE, START, DATA, STOP, CLEANUP; Done high in CLEANUP and the first IDLE cycle.
    int u_state = 0;
    int u_cnt = 0;
    int u_idx = 0;
    logic [7:0] u_data = 8'h00;
    always @(posedge clk) begin
        case (u_state)
            0: begin
                tx_serial <= 1'b1; tx_done <= 1'b0; u_cnt <= 0; u_idx <= 0;
                if (tx_dv) begin tx_active <= 1'b1; u_data <= tx_byte; u_state <= 1; end
            end
            1: begin
                tx_serial <= 1'b0;
                if (u_cnt < CPB-1) u_cnt <= u_cnt + 1; else begin u_cnt <= 0; u_state <= 2; end
            end
            2: begin
                tx_serial <= u_data[u_idx];
                if (u_cnt < CPB-1) u_cnt <= u_cnt + 1;
                else begin
                    u_cnt <= 0;
                    if (u_idx < 7) u_idx <= u_idx + 1; else begin u_idx <= 0; u_state <= 3; end
                end
            end
            3: begin
                tx_serial <= 1'b1;
                if (u_cnt < CPB-1) u_cnt <= u_cnt + 1;
                else begin tx_done <= 1'b1; tx_active <= 1'b0; u_cnt <= 0; u_state <= 4; end
            end
            default: begin tx_done <= 1'b1; u_state <= 0; end
        endcase
    end

    // Requester driver: per-requester byte lists, presented on negedges, advanced after a transfer.
    logic [8:0] src_mem[N][64];
    int src_head[N] = '{default: 0};
    int src_tail[N] = '{default: 0};
    logic [N-1:0] pend = '0;
    always @(negedge clk) begin
        for (int k = 0; k < N; k++) begin
            if (pend[k]) src_head[k]++;
            if (src_head[k] < src_tail[k]) begin
                req_valid[k]      = 1'b1;
                req_data[8*k +: 8] = src_mem[k][src_head[k]][7:0];
                req_last[k]       = src_mem[k][src_head[k]][8];
            end else begin
                req_valid[k] = 1'b0;
                req_last[k]  = 1'b0;
            end
            pend[k] = req_valid[k] & req_ready[k];
        end
    end

    task automatic push_src(input int k, input logic last, input logic [7:0] b);
        src_mem[k][src_tail[k]] = {last, b};
        src_tail[k]++;
    endtask

    function automatic logic src_empty();
        logic e;
        e = 1'b1;
        for (int k = 0; k < N; k++) if (src_head[k] != src_tail[k]) e = 1'b0;
        return e;
    endfunction

    // DV / grant monitor.
    int dv_cnt = 0;
    logic dv_prev = 1'b0;
    logic [N-1:0] glog[$];
    int gdv[$];
    logic [N-1:0] gprev = '0;
    logic rst_mark = 1'b0;
    logic done_after_rst = 1'b0;
    always @(negedge clk) begin
        if (rst_mark && tx_done) done_after_rst = 1'b1;
        if (tx_dv) begin
            dv_cnt++;
            check("dv_tx_free", {30'd0, tx_active, tx_done}, 32'd0);
            check("dv_one_cycle", {31'd0, dv_prev}, 32'd0);
            if (rst_mark) begin
                check("dv_after_done", {31'd0, done_after_rst}, 32'd1);
                rst_mark = 1'b0;
            end
        end
        dv_prev = tx_dv;
        if (grant != gprev) begin
            check("grant_onehot0", {31'd0, $onehot0(grant)}, 32'd1);
            glog.push_back(grant);
            gdv.push_back(dv_cnt);
            gprev = grant;
        end
    end

    // Serial line decoder and scoreboard.
    initial begin
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(negedge clk);
            if (tx_serial === 1'b0) begin
                repeat (CPB/2) @(negedge clk);
                check("line_start", {31'd0, tx_serial}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    b[i] = tx_serial;
                end
                repeat (CPB) @(negedge clk);
                check("line_stop", {31'd0, tx_serial}, 32'd1);
                if (exp_q.size() == 0) check("line_unexpected", {24'd0, b}, 32'h100);
                else check("line_byte", {24'd0, b}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && dbg_state == S_ARB && !tx_active && !tx_done && src_empty())
               && n < 8000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, (n >= 8000)}, 32'd0);
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int n;
        n = 0;
        while (dbg_state != s && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, (n >= 2000)}, 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk); #2 rst_n = 1'b0;
        @(posedge clk); #2 rst_n = 1'b1;
        glog.delete();
        gdv.delete();
    endtask

    initial begin
        int d0;
        int n;
        logic [N-1:0] nz[$];
        logic [N-1:0] ord[8];

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("rst_grant", {28'd0, grant}, 32'd0);
        check("rst_ready", {28'd0, req_ready}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_dv", {31'd0, tx_dv}, 32'd0);
        check("rst_byte", {24'd0, tx_byte}, 32'd0);
        check("rst_rr", {30'd0, dbg_rr}, 32'd0);
        rst_n = 1'b1;

        // One-byte message from req0
        d0 = dv_cnt;
        exp_q.push_back(8'h55);
        push_src(0, 1'b1, 8'h55);
        n = 0;
        while (tx_done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
        check("t1_done_seen", {31'd0, (n >= 2000)}, 32'd0);
        @(negedge clk);
        check("t1_state_arb", {30'd0, dbg_state}, {30'd0, S_ARB});
        check("t1_grant", {28'd0, grant}, 32'd0);
        check("t1_rr", {30'd0, dbg_rr}, 32'd1);
        wait_idle("t1_idle_timeout");
        check("t1_dv_count", dv_cnt - d0, 32'd1);

        // Multi-byte message must not interleave with req2
        do_reset();
        d0 = dv_cnt;
        exp_q.push_back(8'hA1); exp_q.push_back(8'hA2);
        exp_q.push_back(8'hA3); exp_q.push_back(8'hB0);
        push_src(1, 1'b0, 8'hA1); push_src(1, 1'b0, 8'hA2); push_src(1, 1'b1, 8'hA3);
        push_src(2, 1'b1, 8'hB0);
        wait_idle("t2_idle_timeout");
        check("t2_glog_size", glog.size(), 32'd4);
        if (glog.size() == 4) begin
            check("t2_g0", {28'd0, glog[0]}, 32'b0010);
            check("t2_g1", {28'd0, glog[1]}, 32'b0000);
            check("t2_g2", {28'd0, glog[2]}, 32'b0100);
            check("t2_g3", {28'd0, glog[3]}, 32'b0000);
            check("t2_dv_at_release", gdv[1] - d0, 32'd3);
        end

        // All four requesters, two single-byte messages each
        do_reset();
        for (int k = 0; k < N; k++) begin
            push_src(k, 1'b1, 8'h30 + 8'(k));
            push_src(k, 1'b1, 8'h38 + 8'(k));
        end
        for (int k = 0; k < N; k++) exp_q.push_back(8'h30 + 8'(k));
        for (int k = 0; k < N; k++) exp_q.push_back(8'h38 + 8'(k));
        wait_idle("t3_idle_timeout");
        nz.delete();
        foreach (glog[i]) if (glog[i] != '0) nz.push_back(glog[i]);
        ord = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
        check("t3_grant_count", nz.size(), 32'd8);
        if (nz.size() == 8)
            for (int i = 0; i < 8; i++) check("t3_grant_order", {28'd0, nz[i]}, {28'd0, ord[i]});

        // Gap timeout: req3 stalls after a non-last byte while req0 waits
        do_reset();
        exp_q.push_back(8'h10);
        push_src(3, 1'b0, 8'h10);
        n = 0;
        while (grant != 4'b1000 && n < 100) begin @(negedge clk); n++; end
        check("t4_grant3", {28'd0, grant}, 32'b1000);
        exp_q.push_back(8'h20);
        push_src(0, 1'b1, 8'h20);
        d0 = dv_cnt;
        n = 0;
        while (dv_cnt == d0 && n < 100) begin @(negedge clk); n++; end
        check("t4_dv_seen", {31'd0, (n >= 100)}, 32'd0);
        wait_state(S_HOLD, "t4_hold_timeout");
        n = 0;
        while (grant == 4'b1000 && n < 100) begin n++; @(negedge clk); end
        check("t4_hold_cycles", n, 32'd16);
        check("t4_grant_drop", {28'd0, grant}, 32'd0);
        @(negedge clk);
        check("t4_grant0", {28'd0, grant}, 32'b0001);
        wait_idle("t4_idle_timeout");

        // Reset during WAIT_DONE
        do_reset();
        d0 = dv_cnt;
        exp_q.push_back(8'hC3); exp_q.push_back(8'h3C);
        push_src(0, 1'b1, 8'hC3); push_src(0, 1'b1, 8'h3C);
        wait_state(S_WDONE, "t5_wdone_timeout");
        repeat (20) @(negedge clk);
        @(posedge clk); #2 rst_n = 1'b0;
        rst_mark = 1'b1;
        done_after_rst = 1'b0;
        #1;
        check("t5_grant", {28'd0, grant}, 32'd0);
        check("t5_dv", {31'd0, tx_dv}, 32'd0);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_byte", {24'd0, tx_byte}, 32'd0);
        check("t5_active", {31'd0, tx_active}, 32'd1);
        @(posedge clk); #2 rst_n = 1'b1;
        wait_idle("t5_idle_timeout");
        check("t5_dv_count", dv_cnt - d0, 32'd2);
        check("t5_dv_after_rst", {31'd0, rst_mark}, 32'd0);

        repeat (5) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
